mux_arbiter: RTL and testbench

// Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath

---
 rtl/mux_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter sharing one WIDTH-bit 2:1 mux datapath.
// The grant is locked for a whole packet (through the beat flagged last), and
// the selected beat is registered into a one-entry output stage.
module mux_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid_i,
    input  logic             req0_last_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic             req1_last_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic             sel_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             space;
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic             mux_last;
    logic [WIDTH-1:0] mux_data;

    // Mux select, handshakes and the muxed beat, all decoded from the granted state.
    always_comb begin
        sel_o        = (state_q == StGrant1);
        // Output stage can take a beat if empty or being drained this cycle.
        space        = !out_valid_q | out_ready_i;
        req0_ready_o = (state_q == StGrant0) & space;
        req1_ready_o = (state_q == StGrant1) & space;
        accept0      = req0_valid_i & req0_ready_o;
        accept1      = req1_valid_i & req1_ready_o;
        accept       = accept0 | accept1;
        mux_data     = sel_o ? req1_data_i : req0_data_i;
        mux_last     = sel_o ? req1_last_i : req0_last_i;
    end

    // Arbitration: pick the requester that did not win last time on a tie,
    // then hold the grant until its last beat is accepted.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid_i && req1_valid_i) begin
                    if (last_grant_q) begin
                        state_d      = StGrant0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = StGrant1;
                        last_grant_d = 1'b1;
                    end
                end else if (req0_valid_i) begin
                    state_d      = StGrant0;
                    last_grant_d = 1'b0;
                end else if (req1_valid_i) begin
                    state_d      = StGrant1;
                    last_grant_d = 1'b1;
                end
            end
            StGrant0: begin
                if (accept0 && req0_last_i) begin
                    state_d = StIdle;
                end
            end
            StGrant1: begin
                if (accept1 && req1_last_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output stage: load on accept, clear valid on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = mux_last;
            out_data_d  = mux_data;
        end else if (out_ready_i && out_valid_q) begin
            // Data is kept after drain; only valid drops.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight packet and held beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_mux_arbiter;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset_n;
    logic             req0_valid_i, req0_last_i, req0_ready_o;
    logic [WIDTH-1:0] req0_data_i;
    logic             req1_valid_i, req1_last_i, req1_ready_o;
    logic [WIDTH-1:0] req1_data_i;
    logic             out_valid_o, out_last_o, out_ready_i, sel_o;
    logic [WIDTH-1:0] out_data_o;

    int tests_run;
    int tests_failed;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_valid_i (req0_valid_i),
        .req0_last_i  (req0_last_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_last_i  (req1_last_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .out_valid_o  (out_valid_o),
        .out_last_o   (out_last_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .sel_o        (sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected mid-cycle.
    typedef struct packed {
        logic             rst;
        logic             v0;
        logic             l0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic             l1;
        logic [WIDTH-1:0] d1;
        logic             ordy;
        logic             r0;
        logic             r1;
        logic             sel;
        logic             ov;
        logic             ol;
        logic [WIDTH-1:0] od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v0, input logic l0, input logic [15:0] d0,
                       input logic v1, input logic l1, input logic [15:0] d1,
                       input logic ordy, input logic r0, input logic r1, input logic sel,
                       input logic ov, input logic ol, input logic [15:0] od);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.l0 = l0; v.d0 = d0;
        v.v1 = v1; v.l1 = l1; v.d1 = d1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.sel = sel; v.ov = ov; v.ol = ol; v.od = od;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid_i = 1'b0; req0_last_i = 1'b0; req0_data_i = '0;
        req1_valid_i = 1'b0; req1_last_i = 1'b0; req1_data_i = '0;
        out_ready_i  = 1'b1;
    endtask

    // Ends one time unit after a rising edge with the DUT idle.
    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        drive_idle();

        //  rst v0 l0 d0      v1 l1 d1      rdy  r0 r1 sel ov ol od
        // Single 3-beat packet from requester 0.
        add(1, 1, 0, 16'h0A1, 0, 0, 16'h000, 1,  0, 0, 0, 0, 0, 16'h000);
        add(0, 1, 0, 16'h0A1, 0, 0, 16'h000, 1,  1, 0, 0, 0, 0, 16'h000);
        add(0, 1, 0, 16'h0A2, 0, 0, 16'h000, 1,  1, 0, 0, 1, 0, 16'h0A1);
        add(0, 1, 1, 16'h0A3, 0, 0, 16'h000, 1,  1, 0, 0, 1, 0, 16'h0A2);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 1, 1, 16'h0A3);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 0, 1, 16'h0A3);
        // Both requesters continuously valid with 1-beat packets.
        add(1, 1, 1, 16'h111, 1, 1, 16'h222, 1,  0, 0, 0, 0, 0, 16'h000);
        add(0, 1, 1, 16'h111, 1, 1, 16'h222, 1,  1, 0, 0, 0, 0, 16'h000);
        add(0, 1, 1, 16'h111, 1, 1, 16'h222, 1,  0, 0, 0, 1, 1, 16'h111);
        add(0, 1, 1, 16'h111, 1, 1, 16'h222, 1,  0, 1, 1, 0, 1, 16'h111);
        add(0, 1, 1, 16'h111, 1, 1, 16'h222, 1,  0, 0, 0, 1, 1, 16'h222);
        add(0, 1, 1, 16'h111, 1, 1, 16'h222, 1,  1, 0, 0, 0, 1, 16'h222);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 1, 1, 16'h111);
        // Requester 1 stalls mid-packet while requester 0 waits.
        add(1, 0, 0, 16'h000, 1, 0, 16'h0B1, 1,  0, 0, 0, 0, 0, 16'h000);
        add(0, 1, 1, 16'h0C1, 1, 0, 16'h0B1, 1,  0, 1, 1, 0, 0, 16'h000);
        add(0, 1, 1, 16'h0C1, 0, 0, 16'h000, 1,  0, 1, 1, 1, 0, 16'h0B1);
        add(0, 1, 1, 16'h0C1, 0, 0, 16'h000, 1,  0, 1, 1, 0, 0, 16'h0B1);
        add(0, 1, 1, 16'h0C1, 1, 1, 16'h0B2, 1,  0, 1, 1, 0, 0, 16'h0B1);
        add(0, 1, 1, 16'h0C1, 0, 0, 16'h000, 1,  0, 0, 0, 1, 1, 16'h0B2);
        add(0, 1, 1, 16'h0C1, 0, 0, 16'h000, 1,  1, 0, 0, 0, 1, 16'h0B2);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 1, 1, 16'h0C1);
        // Consumer backpressure for 4 cycles, then drain and accept together.
        add(1, 1, 0, 16'h5A5, 0, 0, 16'h000, 1,  0, 0, 0, 0, 0, 16'h000);
        add(0, 1, 0, 16'h5A5, 0, 0, 16'h000, 1,  1, 0, 0, 0, 0, 16'h000);
        add(0, 1, 1, 16'h5A6, 0, 0, 16'h000, 0,  0, 0, 0, 1, 0, 16'h5A5);
        add(0, 1, 1, 16'h5A6, 0, 0, 16'h000, 0,  0, 0, 0, 1, 0, 16'h5A5);
        add(0, 1, 1, 16'h5A6, 0, 0, 16'h000, 0,  0, 0, 0, 1, 0, 16'h5A5);
        add(0, 1, 1, 16'h5A6, 0, 0, 16'h000, 0,  0, 0, 0, 1, 0, 16'h5A5);
        add(0, 1, 1, 16'h5A6, 0, 0, 16'h000, 1,  1, 0, 0, 1, 0, 16'h5A5);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 1, 1, 16'h5A6);
        add(0, 0, 0, 16'h000, 0, 0, 16'h000, 1,  0, 0, 0, 0, 1, 16'h5A6);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req0_valid_i = vecs[i].v0; req0_last_i = vecs[i].l0; req0_data_i = vecs[i].d0;
            req1_valid_i = vecs[i].v1; req1_last_i = vecs[i].l1; req1_data_i = vecs[i].d1;
            out_ready_i  = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d {r0,r1,sel,ov,ol,od}", i),
                  {11'd0, req0_ready_o, req1_ready_o, sel_o, out_valid_o, out_last_o, out_data_o},
                  {11'd0, vecs[i].r0, vecs[i].r1, vecs[i].sel, vecs[i].ov, vecs[i].ol,
                   vecs[i].od});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges in the middle of a requester-1 packet.
        do_reset();
        req1_valid_i = 1'b1; req1_last_i = 1'b0; req1_data_i = 16'h0D1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset {sel,ov,od}", {15'd0, sel_o, out_valid_o, out_data_o},
              {15'd0, 1'b1, 1'b1, 16'h0D1});
        #2;
        reset_n = 1'b0;
        req0_valid_i = 1'b1; req0_last_i = 1'b1; req0_data_i = 16'h0E1;
        #1;
        check("async_reset {r0,r1,sel,ov,ol,od}",
              {11'd0, req0_ready_o, req1_ready_o, sel_o, out_valid_o, out_last_o, out_data_o},
              32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_grant {sel,r0,r1}", {29'd0, sel_o, req0_ready_o, req1_ready_o},
              {29'd0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        check("post_reset_out {ov,ol,od}", {14'd0, out_valid_o, out_last_o, out_data_o},
              {14'd0, 1'b1, 1'b1, 16'h0E1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
